// File: rtl/envelope_bank_if.sv
// Note/step controls into the envelope bank and the per-visit level updates out of it.
interface envelope_bank_if #(
   parameter int VOICES = 8,
   parameter int WIDTH  = 24
);
   localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

   logic [VOICES-1:0] note_on;
   logic [VOICES-1:0] note_off;
   logic [WIDTH-1:0]  attack_step;
   logic [WIDTH-1:0]  decay_step;
   logic [WIDTH-1:0]  release_step;
   logic [WIDTH-1:0]  sustain_level;
   logic              env_valid;
   logic [VW-1:0]     env_voice;
   logic [WIDTH-1:0]  env_data;
   logic [VOICES-1:0] envelope_end;

   modport master (
      output note_on, note_off, attack_step, decay_step, release_step, sustain_level,
      input  env_valid, env_voice, env_data, envelope_end
   );

   modport slave (
      input  note_on, note_off, attack_step, decay_step, release_step, sustain_level,
      output env_valid, env_voice, env_data, envelope_end
   );
endinterface

// File: rtl/envelope_bank.sv
// Time-multiplexed ADSR bank: one shared step datapath visits voice v when the
// tick counter equals v, and reports the new level one cycle later.
module envelope_bank #(
   parameter int VOICES    = 8,
   parameter int WIDTH     = 24,
   parameter int TICK_DIV  = 1042,
   parameter int RETRIGGER = 1
) (
   input  logic           clock_50_000_000,
   input  logic           reset,
   envelope_bank_if.slave bus
);
   localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {S_IDLE, S_ATTACK, S_DECAY, S_SUSTAIN, S_RELEASE} state_e;
   typedef enum logic [1:0] {EV_NONE, EV_ON, EV_OFF} event_e;

   state_e            state_q [VOICES];
   state_e            state_d [VOICES];
   logic [WIDTH-1:0]  level_q [VOICES];
   logic [WIDTH-1:0]  level_d [VOICES];
   event_e            pend_q  [VOICES];
   event_e            pend_d  [VOICES];
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic [VW-1:0]     voice_q, voice_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [VOICES-1:0] end_q, end_d;

   logic              visit;
   logic [VW-1:0]     vidx;
   state_e            cur_st, nxt_st;
   logic [WIDTH-1:0]  cur_lv, nxt_lv;
   logic [WIDTH:0]    atk_sum, dec_diff, rel_diff;
   logic              done;

   assign visit = int'(cnt_q) < VOICES;
   assign vidx  = cnt_q[VW-1:0];

   always_comb begin
      cnt_d   = (cnt_q == CW'(TICK_DIV - 1)) ? '0 : cnt_q + 1'b1;
      state_d = state_q;
      level_d = level_q;
      pend_d  = pend_q;
      valid_d = 1'b0;
      voice_d = voice_q;
      data_d  = data_q;
      end_d   = '0;

      // Pending event is applied before the step, so the visit that consumes it also moves the level.
      cur_st = state_q[vidx];
      cur_lv = level_q[vidx];
      if (pend_q[vidx] == EV_ON) begin
         cur_st = S_ATTACK;
         if (RETRIGGER != 0) cur_lv = '0;
      end else if (pend_q[vidx] == EV_OFF &&
                   (cur_st == S_ATTACK || cur_st == S_DECAY || cur_st == S_SUSTAIN)) begin
         cur_st = S_RELEASE;
      end

      atk_sum  = {1'b0, cur_lv} + {1'b0, bus.attack_step};
      dec_diff = {1'b0, cur_lv} - {1'b0, bus.decay_step};
      rel_diff = {1'b0, cur_lv} - {1'b0, bus.release_step};
      nxt_st   = cur_st;
      nxt_lv   = cur_lv;
      done     = 1'b0;

      unique case (cur_st)
         S_ATTACK: begin
            if (bus.attack_step == '0 || atk_sum >= {1'b0, {WIDTH{1'b1}}}) begin
               nxt_lv = '1;
               nxt_st = S_DECAY;
            end else begin
               nxt_lv = atk_sum[WIDTH-1:0];
            end
         end
         S_DECAY: begin
            if (bus.decay_step == '0 || dec_diff[WIDTH] ||
                dec_diff[WIDTH-1:0] <= bus.sustain_level) begin
               nxt_lv = bus.sustain_level;
               nxt_st = S_SUSTAIN;
            end else begin
               nxt_lv = dec_diff[WIDTH-1:0];
            end
         end
         S_SUSTAIN: nxt_lv = bus.sustain_level;
         S_RELEASE: begin
            if (bus.release_step == '0 || rel_diff[WIDTH] || rel_diff[WIDTH-1:0] == '0) begin
               nxt_lv = '0;
               nxt_st = S_IDLE;
               done   = 1'b1;
            end else begin
               nxt_lv = rel_diff[WIDTH-1:0];
            end
         end
         default: nxt_lv = '0;
      endcase

      // Newest pulse wins; a pulse landing on its own visit survives to the next tick.
      for (int v = 0; v < VOICES; v++) begin
         if (bus.note_on[v])                     pend_d[v] = EV_ON;
         else if (bus.note_off[v])               pend_d[v] = EV_OFF;
         else if (visit && vidx == VW'(v))       pend_d[v] = EV_NONE;
      end

      if (visit) begin
         state_d[vidx] = nxt_st;
         level_d[vidx] = nxt_lv;
         valid_d       = 1'b1;
         voice_d       = vidx;
         data_d        = nxt_lv;
         end_d[vidx]   = done;
      end
   end

   always_ff @(posedge clock_50_000_000) begin
      if (reset) begin
         for (int v = 0; v < VOICES; v++) begin
            state_q[v] <= S_IDLE;
            level_q[v] <= '0;
            pend_q[v]  <= EV_NONE;
         end
         cnt_q   <= '0;
         valid_q <= 1'b0;
         voice_q <= '0;
         data_q  <= '0;
         end_q   <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         voice_q <= voice_d;
         data_q  <= data_d;
         end_q   <= end_d;
      end
   end

   assign bus.env_valid    = valid_q;
   assign bus.env_voice    = voice_q;
   assign bus.env_data     = data_q;
   assign bus.envelope_end = end_q;
endmodule

// File: tb/tb_envelope_bank.sv
// Two banks (retrigger and legato) share one stimulus; an integer model queues
// the expected update of every visit and the monitor pops it when the output lands.
module tb_envelope_bank;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] note_on, note_off;
   logic [7:0] atk, dec, rel, sus;

   always #5 clk = ~clk;

   envelope_bank_if #(.VOICES(4), .WIDTH(8)) bus0 ();
   envelope_bank_if #(.VOICES(4), .WIDTH(8)) bus1 ();

   assign bus0.note_on = note_on;  assign bus1.note_on = note_on;
   assign bus0.note_off = note_off; assign bus1.note_off = note_off;
   assign bus0.attack_step = atk;  assign bus1.attack_step = atk;
   assign bus0.decay_step = dec;   assign bus1.decay_step = dec;
   assign bus0.release_step = rel; assign bus1.release_step = rel;
   assign bus0.sustain_level = sus; assign bus1.sustain_level = sus;

   envelope_bank #(.VOICES(4), .WIDTH(8), .TICK_DIV(8), .RETRIGGER(1)) dut0 (
      .clock_50_000_000(clk), .reset(rst), .bus(bus0.slave));
   envelope_bank #(.VOICES(4), .WIDTH(8), .TICK_DIV(8), .RETRIGGER(0)) dut1 (
      .clock_50_000_000(clk), .reset(rst), .bus(bus1.slave));

   typedef struct {int voice; int d0; int d1; int e0; int e1;} exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   int n_vec = 0, n_err = 0;
   bit mon_en = 1'b0;
   int m_st[2][4], m_lv[2][4], m_pd[4], m_cnt;
   int last0[4], last1[4], end_cnt0[4], end_cnt1[4];
   int v0_log[$];

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // States: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release. Events: 1 on, 2 off.
   task automatic visit(input int d, input int v, output int lv, output int endb);
      int st, n;
      st = m_st[d][v]; lv = m_lv[d][v]; endb = 0;
      if (m_pd[v] == 1) begin st = 1; if (d == 0) lv = 0; end
      else if (m_pd[v] == 2 && st >= 1 && st <= 3) st = 4;
      case (st)
         1: begin n = lv + int'(atk); if (atk == 0 || n >= 255) begin lv = 255; st = 2; end else lv = n; end
         2: begin n = lv - int'(dec); if (dec == 0 || n <= int'(sus)) begin lv = int'(sus); st = 3; end else lv = n; end
         3: lv = int'(sus);
         4: begin n = lv - int'(rel); if (rel == 0 || n <= 0) begin lv = 0; st = 0; endb = 1; end else lv = n; end
         default: lv = 0;
      endcase
      m_st[d][v] = st; m_lv[d][v] = lv;
   endtask

   task automatic cyc();
      exp_t e;
      int lv, eb;
      if (rst) begin
         for (int v = 0; v < 4; v++) begin
            m_st[0][v] = 0; m_st[1][v] = 0; m_lv[0][v] = 0; m_lv[1][v] = 0; m_pd[v] = 0;
         end
         m_cnt = 0;
      end else begin
         if (m_cnt < 4) begin
            e.voice = m_cnt;
            visit(0, m_cnt, lv, eb); e.d0 = lv; e.e0 = eb << m_cnt;
            visit(1, m_cnt, lv, eb); e.d1 = lv; e.e1 = eb << m_cnt;
            exp_q.push_back(e);
         end
         for (int v = 0; v < 4; v++) begin
            if (note_on[v]) m_pd[v] = 1;
            else if (note_off[v]) m_pd[v] = 2;
            else if (m_cnt == v) m_pd[v] = 0;
         end
         m_cnt = (m_cnt + 1) % 8;
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      note_on = '0; note_off = '0;
   endtask

   task automatic ticks(input int n);
      repeat (8 * n) cyc();
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("vld0", int'(bus0.env_valid), 1);
            chk("voice0", int'(bus0.env_voice), mon_e.voice);
            chk("data0", int'(bus0.env_data), mon_e.d0);
            chk("end0", int'(bus0.envelope_end), mon_e.e0);
            chk("vld1", int'(bus1.env_valid), 1);
            chk("voice1", int'(bus1.env_voice), mon_e.voice);
            chk("data1", int'(bus1.env_data), mon_e.d1);
            chk("end1", int'(bus1.envelope_end), mon_e.e1);
            last0[mon_e.voice] = int'(bus0.env_data);
            last1[mon_e.voice] = int'(bus1.env_data);
            if (mon_e.voice == 0) v0_log.push_back(int'(bus0.env_data));
         end else begin
            chk("quiet_vld0", int'(bus0.env_valid), 0);
            chk("quiet_end0", int'(bus0.envelope_end), 0);
            chk("quiet_vld1", int'(bus1.env_valid), 0);
            chk("quiet_end1", int'(bus1.envelope_end), 0);
         end
         for (int v = 0; v < 4; v++) begin
            end_cnt0[v] += int'(bus0.envelope_end[v]);
            end_cnt1[v] += int'(bus1.envelope_end[v]);
         end
      end
   end

   initial begin
      int exp_seq[14] = '{0, 64, 128, 192, 255, 223, 191, 160, 160, 160, 96, 32, 0, 0};
      int saved_end;
      rst = 1'b1; note_on = '0; note_off = '0;
      atk = 8'd64; dec = 8'd32; rel = 8'd64; sus = 8'd160;
      @(negedge clk); #1;
      cyc(); cyc();
      mon_en = 1'b1;
      cyc();
      chk("rst_vld", int'(bus0.env_valid), 0);
      chk("rst_voice", int'(bus0.env_voice), 0);
      chk("rst_data", int'(bus0.env_data), 0);
      chk("rst_end", int'(bus0.envelope_end), 0);
      rst = 1'b0;

      // Attack/decay/sustain on voice 0; the pulse lands on its own visit so it waits a tick.
      note_on[0] = 1'b1;
      ticks(9);
      // Release from sustain.
      note_off[0] = 1'b1;
      ticks(5);
      chk("log_len", v0_log.size(), 14);
      for (int i = 0; i < 14 && i < v0_log.size(); i++) chk("adsr_seq", v0_log[i], exp_seq[i]);
      chk("end_v0", end_cnt0[0], 1);

      // Simultaneous on/off (on wins) and off to an idle voice.
      note_on[2] = 1'b1; note_off[2] = 1'b1; note_off[3] = 1'b1;
      ticks(3);
      chk("onoff_v2", last0[2], 192);
      chk("idle_off_end", end_cnt0[3], 0);

      // Retrigger vs legato from release at 96.
      note_on[1] = 1'b1;
      ticks(7);
      chk("sus_v1", last0[1], 160);
      note_off[1] = 1'b1;
      ticks(1);
      chk("rel_v1_dut0", last0[1], 96);
      chk("rel_v1_dut1", last1[1], 96);
      note_on[1] = 1'b1;
      ticks(1);
      chk("retrig", last0[1], 64);
      chk("legato", last1[1], 160);

      // Zero steps make attack and release instantaneous.
      atk = 8'd0; rel = 8'd0;
      note_on[3] = 1'b1;
      ticks(1);
      chk("inst_atk", last0[3], 255);
      note_off[3] = 1'b1;
      ticks(1);
      chk("inst_rel", last0[3], 0);
      chk("inst_end0", end_cnt0[3], 1);
      chk("inst_end1", end_cnt1[3], 1);

      // Reset mid-sweep while voice 1 is releasing.
      atk = 8'd64; rel = 8'd16;
      note_off[1] = 1'b1;
      ticks(1);
      cyc(); cyc();
      saved_end = end_cnt0[1];
      rst = 1'b1;
      cyc(); cyc();
      chk("mid_rst_vld", int'(bus0.env_valid), 0);
      chk("mid_rst_data", int'(bus0.env_data), 0);
      chk("mid_rst_end", int'(bus0.envelope_end), 0);
      rst = 1'b0;
      cyc();
      chk("post_rst_vld", int'(bus0.env_valid), 1);
      chk("post_rst_voice", int'(bus0.env_voice), 0);
      chk("post_rst_data", int'(bus0.env_data), 0);
      ticks(4);
      chk("aborted_end", end_cnt0[1], saved_end);
      chk("queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
